// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I-subset core: FETCH over a req/ack instruction port, EXEC one instruction, HALT sticky on ebreak/illegal.
// Register file is RV32I (32 entries) or RV32E (16 entries) selected by NREG.
module rv_mc_core #(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] exit_code,
  output logic [31:0] fault_pc,
  output logic [31:0] dbg_pc,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  localparam int AW = (NREG == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] rf_q [NREG];

  logic        rf_we;
  logic [31:0] rf_wdata;

  // Architectural index check; RV32E only has x0..x15.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (NREG == 32) || !idx[4];
  endfunction

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_j;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  logic [31:0] rs1_val, rs2_val, a0_val;

  assign rs1_val   = (idx_ok(rs1) && rs1 != 5'd0) ? rf_q[rs1[AW-1:0]] : 32'd0;
  assign rs2_val   = (idx_ok(rs2) && rs2 != 5'd0) ? rf_q[rs2[AW-1:0]] : 32'd0;
  assign a0_val    = rf_q[10];
  assign dbg_rdata = (idx_ok(dbg_raddr) && dbg_raddr != 5'd0) ? rf_q[dbg_raddr[AW-1:0]] : 32'd0;

  logic        legal;
  logic        is_ebreak;
  logic [31:0] wb_val;
  logic [31:0] next_pc;
  logic [31:0] target;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    exit_code_d = exit_code_q;
    fault_pc_d  = fault_pc_q;
    rf_we       = 1'b0;
    rf_wdata    = 32'd0;
    legal       = 1'b0;
    is_ebreak   = 1'b0;
    wb_val      = 32'd0;
    next_pc     = pc_q + 32'd4;
    target      = 32'd0;

    unique case (opcode)
      OPC_OP_IMM: begin
        legal  = (funct3 == 3'd0) && idx_ok(rs1) && idx_ok(rd);
        wb_val = rs1_val + imm_i;
      end
      OPC_OP: begin
        legal  = (funct3 == 3'd0) && (funct7 == 7'h00 || funct7 == 7'h20)
                 && idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd);
        wb_val = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
      end
      OPC_LUI: begin
        legal  = idx_ok(rd);
        wb_val = imm_u;
      end
      OPC_AUIPC: begin
        legal  = idx_ok(rd);
        wb_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        target  = pc_q + imm_j;
        legal   = idx_ok(rd) && !target[1];
        wb_val  = pc_q + 32'd4;
        next_pc = target;
      end
      OPC_JALR: begin
        // rs1_val is sampled before the write, so rd == rs1 jumps to the old value.
        target  = (rs1_val + imm_i) & ~32'd1;
        legal   = (funct3 == 3'd0) && idx_ok(rs1) && idx_ok(rd) && !target[1];
        wb_val  = pc_q + 32'd4;
        next_pc = target;
      end
      default: begin
        is_ebreak = (ir_q == EBREAK);
      end
    endcase

    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_ebreak) begin
          state_d     = S_HALT;
          halted_d    = 1'b1;
          illegal_d   = 1'b0;
          exit_code_d = a0_val;
          fault_pc_d  = pc_q;
        end else if (!legal) begin
          state_d     = S_HALT;
          halted_d    = 1'b1;
          illegal_d   = 1'b1;
          exit_code_d = ir_q;
          fault_pc_d  = pc_q;
        end else begin
          rf_we    = 1'b1;
          rf_wdata = wb_val;
          pc_d     = next_pc;
          state_d  = S_FETCH;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      exit_code_q <= 32'd0;
      fault_pc_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      exit_code_q <= exit_code_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  // NOTE: the register file is cleared on reset because software-visible state must start at zero;
  // this rules out mapping it onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= 32'd0;
    end else if (rf_we && rd != 5'd0) begin
      rf_q[rd[AW-1:0]] <= rf_wdata;
    end
  end

  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign exit_code = exit_code_q;
  assign fault_pc  = fault_pc_q;
  assign dbg_pc    = pc_q;

endmodule
